// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and constants for the FFT frame sequencer and its peak tracker.
package fft_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    CONFIG,
    IDLE,
    STREAM
  } state_e;

  localparam logic [15:0] DEFAULT_CONFIG_WORD = 16'h0001;

  function automatic int nfft_len(input int log2_nfft);
    return 1 << log2_nfft;
  endfunction

endpackage

// File: rtl/fft_peak_tracker.sv
// Finds the largest magnitude among bins 1..NFFT/2-1 of each FFT output frame.
// Result registered one cycle after the last beat; the magnitude stream is never stalled.
module fft_peak_tracker
  import fft_frame_sequencer_pkg::*;
#(
  parameter int LOG2_NFFT = 10,
  parameter int MAG_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MAG_WIDTH-1:0] mag_i,
  input  logic                 mag_vld_i,
  input  logic                 mag_last_i,
  output logic [LOG2_NFFT-1:0] peak_bin_o,
  output logic [MAG_WIDTH-1:0] peak_mag_o,
  output logic                 peak_vld_o,
  output logic [15:0]          frame_count_o,
  output logic                 frame_error_o
);

  localparam int NFFT = nfft_len(LOG2_NFFT);
  localparam logic [LOG2_NFFT-1:0] BIN_LAST = LOG2_NFFT'(NFFT - 1);
  localparam logic [LOG2_NFFT-1:0] BIN_HALF = LOG2_NFFT'(NFFT / 2);

  logic [LOG2_NFFT-1:0] bin_q, bin_d;
  logic [LOG2_NFFT-1:0] best_bin_q, best_bin_d;
  logic [MAG_WIDTH-1:0] best_mag_q, best_mag_d;
  logic                 past_end_q, past_end_d;
  logic [LOG2_NFFT-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_WIDTH-1:0] peak_mag_q, peak_mag_d;
  logic                 peak_vld_q, peak_vld_d;
  logic [15:0]          fc_q, fc_d;
  logic                 err_q, err_d;

  logic                 take;
  logic [LOG2_NFFT-1:0] cand_bin;
  logic [MAG_WIDTH-1:0] cand_mag;

  // Strict compare keeps the lower bin on ties; DC and the mirrored half never qualify.
  assign take     = (bin_q != '0) && (bin_q < BIN_HALF) && (mag_i > best_mag_q);
  assign cand_bin = take ? bin_q : best_bin_q;
  assign cand_mag = take ? mag_i : best_mag_q;

  always_comb begin
    bin_d      = bin_q;
    best_bin_d = best_bin_q;
    best_mag_d = best_mag_q;
    past_end_d = past_end_q;
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;
    peak_vld_d = 1'b0;
    fc_d       = fc_q;
    err_d      = err_q;
    if (mag_vld_i) begin
      bin_d      = bin_q + 1'b1;
      past_end_d = 1'b0;
      if (past_end_q) err_d = 1'b1;
      if (mag_last_i) begin
        peak_bin_d = cand_bin;
        peak_mag_d = cand_mag;
        peak_vld_d = 1'b1;
        fc_d       = fc_q + 16'd1;
        if (bin_q != BIN_LAST) err_d = 1'b1;
        bin_d      = '0;
        best_bin_d = '0;
        best_mag_d = '0;
      end else begin
        best_bin_d = cand_bin;
        best_mag_d = cand_mag;
        past_end_d = (bin_q == BIN_LAST);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q      <= '0;
      best_bin_q <= '0;
      best_mag_q <= '0;
      past_end_q <= 1'b0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
      peak_vld_q <= 1'b0;
      fc_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      best_bin_q <= best_bin_d;
      best_mag_q <= best_mag_d;
      past_end_q <= past_end_d;
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
      peak_vld_q <= peak_vld_d;
      fc_q       <= fc_d;
      err_q      <= err_d;
    end
  end

  assign peak_bin_o    = peak_bin_q;
  assign peak_mag_o    = peak_mag_q;
  assign peak_vld_o    = peak_vld_q;
  assign frame_count_o = fc_q;
  assign frame_error_o = err_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Configures the FFT once, frames the mono stream into NFFT-sample frames and reports per-frame peaks.
// One cycle input-to-output latency; FFT back-pressure is absorbed by one holding register, overflow is dropped.
module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
#(
  parameter int          DATA_WIDTH  = 16,
  parameter int          LOG2_NFFT   = 10,
  parameter int          MAG_WIDTH   = 32,
  parameter logic [15:0] CONFIG_WORD = DEFAULT_CONFIG_WORD
) (
  input  logic                  axis_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic [15:0]           cfg_data,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  input  logic [MAG_WIDTH-1:0]  fft_mag,
  input  logic                  fft_mag_valid,
  input  logic                  fft_mag_last,
  output logic [LOG2_NFFT-1:0]  peak_bin,
  output logic [MAG_WIDTH-1:0]  peak_mag,
  output logic                  peak_valid,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count,
  output logic                  frame_error
);

  localparam int NFFT = nfft_len(LOG2_NFFT);
  localparam logic [LOG2_NFFT-1:0] IDX_LAST = LOG2_NFFT'(NFFT - 1);

  state_e                state_q, state_d;
  logic [LOG2_NFFT-1:0]  idx_q, idx_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  hold_last_q, hold_last_d;
  logic [DATA_WIDTH-1:0] hold_dat_q, hold_dat_d;
  logic                  cfg_vld_q, cfg_vld_d;
  logic [15:0]           drop_q, drop_d;

  // Frame boundaries come from the internal index, not from the source.
  logic unused_last;
  assign unused_last = s_axis_last;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_vld_d  = hold_vld_q;
    hold_last_d = hold_last_q;
    hold_dat_d  = hold_dat_q;
    drop_d      = drop_q;
    if (hold_vld_q && m_axis_ready) hold_vld_d = 1'b0;
    case (state_q)
      CONFIG: begin
        if (cfg_vld_q && cfg_ready) state_d = IDLE;
      end
      IDLE: begin
        if (enable) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (s_axis_valid) begin
          if (!hold_vld_q || m_axis_ready) begin
            hold_vld_d  = 1'b1;
            hold_dat_d  = s_axis_data;
            hold_last_d = (idx_q == IDX_LAST);
            idx_d       = idx_q + 1'b1;
            if ((idx_q == IDX_LAST) && !enable) state_d = IDLE;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      default: state_d = CONFIG;
    endcase
    // Registered so cfg_valid stays low while reset is held.
    cfg_vld_d = (state_d == CONFIG);
  end

  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      state_q     <= CONFIG;
      idx_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_last_q <= 1'b0;
      hold_dat_q  <= '0;
      cfg_vld_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_vld_q  <= hold_vld_d;
      hold_last_q <= hold_last_d;
      hold_dat_q  <= hold_dat_d;
      cfg_vld_q   <= cfg_vld_d;
      drop_q      <= drop_d;
    end
  end

  assign s_axis_ready = (state_q != CONFIG);
  assign m_axis_data  = hold_dat_q;
  assign m_axis_valid = hold_vld_q;
  assign m_axis_last  = hold_last_q;
  assign cfg_data     = CONFIG_WORD;
  assign cfg_valid    = cfg_vld_q;
  assign drop_count   = drop_q;

  fft_peak_tracker #(
    .LOG2_NFFT (LOG2_NFFT),
    .MAG_WIDTH (MAG_WIDTH)
  ) u_peak (
    .clk_i         (axis_clk),
    .rst_i         (reset),
    .mag_i         (fft_mag),
    .mag_vld_i     (fft_mag_valid),
    .mag_last_i    (fft_mag_last),
    .peak_bin_o    (peak_bin),
    .peak_mag_o    (peak_mag),
    .peak_vld_o    (peak_valid),
    .frame_count_o (frame_count),
    .frame_error_o (frame_error)
  );

endmodule
